inst_queue_ir: RTL



---
 rtl/inst_queue_ir.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/inst_queue_ir.sv
// -----------------------------------------------------------------------------
// inst_queue_ir
//
// Prefetch instruction queue in front of the instruction register. Words from
// instruction RAM are pushed into a DEPTH-entry FIFO with a valid/ready
// handshake. IR_Load pops the head word and decodes it into the IR fields
// (Opcode | Source_Reg1 | Source_Reg2 | Dest_Reg, MSB to LSB). Flush empties
// the queue and invalidates the IR on a taken branch.
//
// Optional feature (compile-time macro IR_BYPASS_EN):
//   defined   - with the queue empty, a word arriving together with IR_Load is
//               decoded straight into the IR in the same edge (no queue write).
//   undefined - that word is queued normally and IR_Valid drops for the edge.
//
// Ports:
//   Clk, Rst       clock (rising edge), asynchronous active-high reset
//   Ram_Inst_Out   instruction word from RAM
//   Inst_Valid     Ram_Inst_Out is valid this cycle
//   Inst_Ready     queue can accept a word (Count < DEPTH)
//   IR_Load        pop the head word into the IR fields
//   Flush          discard queue contents, invalidate IR (fields hold)
//   Opcode, Source_Reg1, Source_Reg2, Dest_Reg   decoded IR fields
//   IR_Valid       IR fields hold a live instruction
//   Count          current queue occupancy
// -----------------------------------------------------------------------------
module inst_queue_ir #(
    parameter int OPCODE_WIDTH = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int INST_WIDTH   = OPCODE_WIDTH + 3 * ADDR_WIDTH,
    parameter int DEPTH        = 4,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [INST_WIDTH-1:0]   Ram_Inst_Out,
    input  logic                    Inst_Valid,
    output logic                    Inst_Ready,
    input  logic                    IR_Load,
    input  logic                    Flush,
    output logic [OPCODE_WIDTH-1:0] Opcode,
    output logic [ADDR_WIDTH-1:0]   Source_Reg1,
    output logic [ADDR_WIDTH-1:0]   Source_Reg2,
    output logic [ADDR_WIDTH-1:0]   Dest_Reg,
    output logic                    IR_Valid,
    output logic [CNT_WIDTH-1:0]    Count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Field positions inside an instruction word.
    localparam int OPC_LSB  = 3 * ADDR_WIDTH;
    localparam int SRC1_LSB = 2 * ADDR_WIDTH;
    localparam int SRC2_LSB = ADDR_WIDTH;

    // Queue storage (deliberately not reset; only pointers/count/IR are).
    logic [INST_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0]   src1_q, src1_d;
    logic [ADDR_WIDTH-1:0]   src2_q, src2_d;
    logic [ADDR_WIDTH-1:0]   dest_q, dest_d;
    logic                    ir_valid_q, ir_valid_d;

    logic                    inst_ready;
    logic                    push;
    logic                    pop;
    logic                    bypass;
    logic                    wr_en;
    logic [INST_WIDTH-1:0]   load_word;

    // Ready looks at occupancy only, so a full queue refuses a word even when
    // a pop happens in the same cycle. Keeps the RAM-side path short.
    assign inst_ready = (count_q < CNT_WIDTH'(DEPTH));

    always_comb begin
        pop    = IR_Load && (count_q != '0);
        bypass = 1'b0;
`ifdef IR_BYPASS_EN
        bypass = (count_q == '0) && Inst_Valid && IR_Load && !Flush;
`endif
        // A bypassed word goes to the IR only; it never occupies a slot.
        push   = Inst_Valid && inst_ready && !bypass;
        wr_en  = push && !Flush;
        // Bypass selects the incoming word, otherwise the queue head.
        load_word = bypass ? Ram_Inst_Out : mem[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        opcode_d   = opcode_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        dest_d     = dest_q;
        ir_valid_d = ir_valid_q;

        if (Flush) begin
            // Flush wins over push and pop; IR fields are left as they were.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ir_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            if (push && !pop) begin
                count_d = count_q + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_WIDTH'(1);
            end

            if (pop || bypass) begin
                opcode_d   = load_word[OPC_LSB  +: OPCODE_WIDTH];
                src1_d     = load_word[SRC1_LSB +: ADDR_WIDTH];
                src2_d     = load_word[SRC2_LSB +: ADDR_WIDTH];
                dest_d     = load_word[0        +: ADDR_WIDTH];
                ir_valid_d = 1'b1;
            end else if (IR_Load) begin
                // Load from an empty queue: nothing to consume, fields hold.
                ir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            opcode_q   <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            dest_q     <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            opcode_q   <= opcode_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            dest_q     <= dest_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= Ram_Inst_Out;
        end
    end

    assign Inst_Ready  = inst_ready;
    assign Opcode      = opcode_q;
    assign Source_Reg1 = src1_q;
    assign Source_Reg2 = src2_q;
    assign Dest_Reg    = dest_q;
    assign IR_Valid    = ir_valid_q;
    assign Count       = count_q;

endmodule
